// File: rtl/fp_cmp_scheduler.sv
// Round-robin scheduler sharing one registered FP32 comparator among NREQ
// requesters: accept one operand pair, wait out the comparator latency,
// return gr/lr/eq tagged with the requester id.
module fp_cmp_scheduler #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int CMP_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [31:0]          cmp_a,
   output logic [31:0]          cmp_b,
   input  logic                 cmp_gr,
   input  logic                 cmp_lr,
   input  logic                 cmp_eq,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_gr,
   output logic                 rsp_lr,
   output logic                 rsp_eq,
   output logic                 busy
);

   localparam int unsigned NR   = NREQ;
   localparam int          CNTW = $clog2(CMP_LAT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] id_reg;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] ptr_nxt;
   logic           grant_any;
   logic [CNTW-1:0] cnt;
   logic [31:0]    sel_a, sel_b;
   int unsigned    idx;

   // Round-robin winner: first valid requester at or after rr_ptr, with wrap
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NR; i++) begin
         idx = (32'(rr_ptr) + i) % NR;
         if (!grant_any && req_valid[IDW'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(idx);
         end
      end
   end

   assign sel_a   = 32'(req_a >> (32 * grant_idx));
   assign sel_b   = 32'(req_b >> (32 * grant_idx));
   assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   assign busy    = (state != IDLE);

   // One-hot accept, only while idle and out of reset
   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && grant_any)
         req_ready[grant_idx] = 1'b1;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: issue operands, count down latency, capture and hold result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         id_reg    <= '0;
         cnt       <= '0;
         cmp_a     <= '0;
         cmp_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_gr    <= 1'b0;
         rsp_lr    <= 1'b0;
         rsp_eq    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  cmp_a  <= sel_a;
                  cmp_b  <= sel_b;
                  id_reg <= grant_idx;
                  rr_ptr <= ptr_nxt;
                  cnt    <= CNTW'(CMP_LAT);
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_gr    <= cmp_gr;
                  rsp_lr    <= cmp_lr;
                  rsp_eq    <= cmp_eq;
                  rsp_id    <= id_reg;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// Bench for fp_cmp_scheduler: two instances (comparator latency 1 and 3),
// each with a latency-accurate comparator stand-in and a transaction-level
// reference model checked every cycle, plus directed literal checks on lane 0.
module tb_fp_cmp_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   rv  [2];
   logic [127:0] ra  [2];
   logic [127:0] rb  [2];
   logic [3:0]   rr  [2];
   logic [31:0]  ca  [2];
   logic [31:0]  cb  [2];
   logic         cg  [2];
   logic         cl  [2];
   logic         ce  [2];
   logic         sv  [2];
   logic         sr  [2];
   logic [1:0]   sid [2];
   logic         sg  [2];
   logic         sl  [2];
   logic         se  [2];
   logic         bz  [2];

   fp_cmp_scheduler #(.NREQ(4), .IDW(2), .CMP_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_a(ra[0]), .req_b(rb[0]),
      .req_ready(rr[0]), .cmp_a(ca[0]), .cmp_b(cb[0]), .cmp_gr(cg[0]),
      .cmp_lr(cl[0]), .cmp_eq(ce[0]), .rsp_valid(sv[0]), .rsp_ready(sr[0]),
      .rsp_id(sid[0]), .rsp_gr(sg[0]), .rsp_lr(sl[0]), .rsp_eq(se[0]),
      .busy(bz[0]));

   fp_cmp_scheduler #(.NREQ(4), .IDW(2), .CMP_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_a(ra[1]), .req_b(rb[1]),
      .req_ready(rr[1]), .cmp_a(ca[1]), .cmp_b(cb[1]), .cmp_gr(cg[1]),
      .cmp_lr(cl[1]), .cmp_eq(ce[1]), .rsp_valid(sv[1]), .rsp_ready(sr[1]),
      .rsp_id(sid[1]), .rsp_gr(sg[1]), .rsp_lr(sl[1]), .rsp_eq(se[1]),
      .busy(bz[1]));

   function automatic int lat(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
      shortreal x, y;
      x = $bitstoshortreal(a);
      y = $bitstoshortreal(b);
      return {x > y, x < y, x == y};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: return 32'h3F800000;
         1: return 32'h40000000;
         2: return 32'hC0400000;
         3: return 32'h00000000;
         4: return 32'h80000000;
         default: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      endcase
   endfunction

   // Comparator stand-in: result valid only once the same operands have been
   // sampled on LAT consecutive edges; before that it shows the impossible
   // pattern 3'b111 so any early capture is visible.
   logic [63:0] prev_ab [2] = '{64'd0, 64'd0};
   logic [2:0]  age     [2] = '{3'd0, 3'd0};
   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if ({ca[l], cb[l]} == prev_ab[l]) age[l] <= (age[l] == 3'd7) ? 3'd7 : age[l] + 3'd1;
         else                              age[l] <= 3'd1;
         prev_ab[l] <= {ca[l], cb[l]};
      end
   end
   assign {cg[0], cl[0], ce[0]} = (int'(age[0]) >= 1) ? fcmp(prev_ab[0][63:32], prev_ab[0][31:0]) : 3'b111;
   assign {cg[1], cl[1], ce[1]} = (int'(age[1]) >= 3) ? fcmp(prev_ab[1][63:32], prev_ab[1][31:0]) : 3'b111;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit done0    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d t=%0t: got %h, expected %h", nm, l, $time, act, exp);
      end
   endtask

   // Transaction-level reference model, one per lane
   int          m_ptr  [2];
   bit          m_infl [2];
   int          m_wait [2];
   bit          m_rv   [2];
   int          m_pid  [2];
   logic [2:0]  m_pres [2];
   int          m_id   [2];
   logic [2:0]  m_res  [2];
   logic [31:0] m_a    [2];
   logic [31:0] m_b    [2];
   logic [3:0]  acc    [2];

   task automatic model_reset(input int l);
      m_ptr[l] = 0; m_infl[l] = 0; m_wait[l] = 0; m_rv[l] = 0;
      m_pid[l] = 0; m_pres[l] = 3'b000; m_id[l] = 0; m_res[l] = 3'b000;
      m_a[l] = '0; m_b[l] = '0; acc[l] = 4'h0;
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
   end

   // Compare process: check outputs against the model, then advance the
   // model across the coming clock edge using the inputs now applied.
   initial forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         int g;
         int idx;
         logic [3:0] er;
         if (rst) model_reset(l);
         g = -1;
         if (!rst && !m_infl[l]) begin
            for (int k = 0; k < 4; k++) begin
               idx = (m_ptr[l] + k) % 4;
               if (g < 0 && rv[l][idx]) g = idx;
            end
         end
         er = (g >= 0) ? 4'(1 << g) : 4'h0;
         chk("req_ready", l, 32'(rr[l]), 32'(er));
         chk("busy",      l, 32'(bz[l]), 32'(m_infl[l]));
         chk("rsp_valid", l, 32'(sv[l]), 32'(m_rv[l]));
         chk("rsp_id",    l, 32'(sid[l]), 32'(m_id[l]));
         chk("rsp_flags", l, 32'({sg[l], sl[l], se[l]}), 32'(m_res[l]));
         chk("cmp_a",     l, ca[l], m_a[l]);
         chk("cmp_b",     l, cb[l], m_b[l]);
         acc[l] = er;
         if (!rst) begin
            if (g >= 0) begin
               m_a[l]    = ra[l][32*g +: 32];
               m_b[l]    = rb[l][32*g +: 32];
               m_pid[l]  = g;
               m_pres[l] = fcmp(m_a[l], m_b[l]);
               m_ptr[l]  = (g + 1) % 4;
               m_infl[l] = 1;
               m_wait[l] = lat(l) + 1;
            end else if (m_infl[l] && !m_rv[l]) begin
               m_wait[l]--;
               if (m_wait[l] == 0) begin
                  m_rv[l]  = 1;
                  m_id[l]  = m_pid[l];
                  m_res[l] = m_pres[l];
               end
            end else if (m_rv[l] && sr[l]) begin
               m_rv[l]   = 0;
               m_infl[l] = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int l, input int i, input logic [31:0] a, input logic [31:0] b);
      ra[l][32*i +: 32] = a;
      rb[l][32*i +: 32] = b;
      rv[l][i] = 1'b1;
   endtask

   task automatic rand_traffic(input int l, input int cycles);
      logic [31:0] a, b;
      for (int c = 0; c < cycles; c++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            if (acc[l][i]) rv[l][i] = 1'b0;
            else if (rv[l][i] && $urandom_range(0, 39) == 0) rv[l][i] = 1'b0;
            else if (!rv[l][i] && $urandom_range(0, 2) == 0) begin
               a = rnd_fp();
               b = ($urandom_range(0, 3) == 0) ? a : rnd_fp();
               set_req(l, i, a, b);
            end
         end
         sr[l] = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic wait_grant(input bit keep, output int idx);
      idx = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if ((rr[0] & rv[0]) != 4'h0) begin
            for (int i = 0; i < 4; i++) if (rr[0][i]) idx = i;
            break;
         end
      end
      if (idx < 0) begin
         n_checks++; n_fail++;
         $display("FAIL grant_timeout lane0 t=%0t: no grant in 40 cycles, expected one", $time);
      end
      tick();
      if (idx >= 0) begin
         if (keep) set_req(0, idx, rnd_fp(), rnd_fp());
         else      rv[0][idx] = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      bit ok;
      ok = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (sv[0]) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL rsp_timeout lane0 t=%0t: rsp_valid=0, expected 1 within 40 cycles", $time);
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (!bz[0] && !sv[0]) break;
      end
      tick();
   endtask

   task automatic do_reset();
      tick(); rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Lane 1 (latency 3) runs random traffic for the whole test
   initial begin
      rv[1] = 4'h0; ra[1] = '0; rb[1] = '0; sr[1] = 1'b1;
      while (!done0) rand_traffic(1, 1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, n, t_prev;
      bit found;
      rv[0] = 4'h0; ra[0] = '0; rb[0] = '0; sr[0] = 1'b1;

      // Single request: 1.0 vs 2.0
      set_req(0, 0, 32'h3F800000, 32'h40000000);
      tick(); tick(); tick();
      rst = 1'b0;
      wait_grant(0, g);
      chk("t1_grant", 0, 32'(g), 32'd0);
      chk("t1_cmp_a", 0, ca[0], 32'h3F800000);
      chk("t1_cmp_b", 0, cb[0], 32'h40000000);
      n = 0; found = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); n++; #1;
         if (sv[0]) begin found = 1; break; end
      end
      chk("t1_found",   0, 32'(found), 32'd1);
      chk("t1_latency", 0, 32'(n), 32'd2);
      chk("t1_id",      0, 32'(sid[0]), 32'd0);
      chk("t1_flags",   0, 32'({sg[0], sl[0], se[0]}), 32'b010);

      // Round-robin with all requesters valid through reset release
      wait_idle();
      for (int i = 0; i < 4; i++) set_req(0, i, rnd_fp(), rnd_fp());
      do_reset();
      t_prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(1, g);
         chk("t2_order", 0, 32'(g), 32'(k % 4));
         if (k > 0) chk("t2_period", 0, 32'(cyc - t_prev), 32'd4);
         t_prev = cyc;
      end
      rv[0] = 4'h0;

      // Backpressure on an equal-operand result
      wait_idle();
      sr[0] = 1'b0;
      set_req(0, 0, 32'hC0400000, 32'hC0400000);
      wait_grant(0, g);
      chk("t3_grant", 0, 32'(g), 32'd0);
      set_req(0, 1, rnd_fp(), rnd_fp());
      wait_rsp();
      for (int c = 0; c < 10; c++) begin
         chk("t3_hold_valid", 0, 32'(sv[0]), 32'd1);
         chk("t3_hold_id",    0, 32'(sid[0]), 32'd0);
         chk("t3_hold_eq",    0, 32'({sg[0], sl[0], se[0]}), 32'b001);
         chk("t3_no_ready",   0, 32'(rr[0]), 32'd0);
         @(negedge clk); #1;
      end
      tick(); sr[0] = 1'b1;
      @(posedge clk); #1;
      chk("t3_release", 0, 32'(sv[0]), 32'd0);
      wait_grant(0, g);
      chk("t3_next", 0, 32'(g), 32'd1);

      // Pointer wrap: req3 alone, then req0 and req1 together
      wait_idle();
      rv[0] = 4'h0;
      do_reset();
      set_req(0, 3, rnd_fp(), rnd_fp());
      wait_grant(0, g);
      chk("t4_first", 0, 32'(g), 32'd3);
      set_req(0, 0, rnd_fp(), rnd_fp());
      set_req(0, 1, rnd_fp(), rnd_fp());
      wait_grant(0, g);
      chk("t4_wrap0", 0, 32'(g), 32'd0);
      wait_grant(0, g);
      chk("t4_then1", 0, 32'(g), 32'd1);

      // Reset one cycle after accept discards the transaction
      wait_idle();
      set_req(0, 2, 32'h40000000, 32'h3F800000);
      wait_grant(0, g);
      chk("t5_grant", 0, 32'(g), 32'd2);
      tick(); rst = 1'b1;
      @(negedge clk); #1;
      chk("t5_rst_valid", 0, 32'(sv[0]), 32'd0);
      chk("t5_rst_busy",  0, 32'(bz[0]), 32'd0);
      chk("t5_rst_cmp_a", 0, ca[0], 32'd0);
      chk("t5_rst_ready", 0, 32'(rr[0]), 32'd0);
      set_req(0, 2, 32'h40000000, 32'h3F800000);
      tick(); rst = 1'b0;
      wait_grant(0, g);
      chk("t5_regrant", 0, 32'(g), 32'd2);
      wait_rsp();
      chk("t5_id",    0, 32'(sid[0]), 32'd2);
      chk("t5_flags", 0, 32'({sg[0], sl[0], se[0]}), 32'b100);

      // Random traffic on lane 0
      rand_traffic(0, 2000);
      done0 = 1'b1;
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
